spi_flash_read_ctrl: RTL and testbench

- SPI master for the external flash. Sits directly downstream of the mmu's external-storage address decode.
- The mmu issues a read request with a 24-bit byte address. The block sends READ opcode 0x03 plus the address, shifts in 4 data bytes and returns one 32-bit word with a single-cycle valid pulse.
- Its SPI pins are muxed by the mmu with the programming-SPI passthrough, so the pins are idle whenever the block is idle.

---
 rtl/spi_flash_read_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spi_flash_read_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_read_ctrl.sv
// SPI mode-0 master that reads one 32-bit little-endian word from serial flash per request.
// Optional macro SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B) with 8 dummy bits.
module spi_flash_read_ctrl #(
    parameter int CLK_DIV        = 2,
    parameter int CS_HIGH_CYCLES = 4,
    parameter int DATA_BYTES     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [23:0] addr_i,
    output logic        busy_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        spi_cs_n_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE     = 8'h0B;
    localparam int         DUMMY_BITS = 8;
`else
    localparam logic [7:0] OPCODE     = 8'h03;
    localparam int         DUMMY_BITS = 0;
`endif
    localparam int ADDR_START = 8;
    localparam int ADDR_END   = 32;
    localparam int TOTAL_BITS = ADDR_END + DUMMY_BITS + 8 * DATA_BYTES;
    localparam int GW         = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
        DUMMY,
`endif
        DATA,
        GUARD
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      div_q, div_d;
    logic [6:0]      bit_q, bit_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic [31:0]     tx_q, tx_d;
    logic [31:0]     rx_q, rx_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            sck_q, sck_d;
    logic            cs_n_q, cs_n_d;
    logic            mosi_q, mosi_d;
    logic            half_done;
    logic [6:0]      next_bit;

    assign half_done = (div_q == 8'(CLK_DIV - 1));
    assign next_bit  = bit_q + 7'd1;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        guard_d  = guard_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        sck_d    = sck_q;
        cs_n_d   = cs_n_q;
        mosi_d   = mosi_q;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = CMD;
                    tx_d    = {OPCODE, addr_i};
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    mosi_d  = OPCODE[7];
                    div_d   = 8'd0;
                    bit_d   = 7'd0;
                end
            end
            GUARD: begin
                if (guard_q == GW'(CS_HIGH_CYCLES - 1)) begin
                    state_d = IDLE;
                    guard_d = '0;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            default: begin
                if (!half_done) begin
                    div_d = div_q + 8'd1;
                end else if (!sck_q) begin
                    div_d = 8'd0;
                    sck_d = 1'b1;
                    if (state_q == DATA) rx_d = {rx_q[30:0], spi_miso_i};
                end else if (bit_q == 7'(TOTAL_BITS - 1)) begin
                    div_d    = 8'd0;
                    state_d  = GUARD;
                    sck_d    = 1'b0;
                    cs_n_d   = 1'b1;
                    mosi_d   = 1'b0;
                    rvalid_d = 1'b1;
                    guard_d  = '0;
                    rdata_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                end else begin
                    div_d  = 8'd0;
                    sck_d  = 1'b0;
                    bit_d  = next_bit;
                    // Zeros shift in behind the address, so dummy and data bits drive MOSI low.
                    tx_d   = {tx_q[30:0], 1'b0};
                    mosi_d = tx_q[30];
                    if (next_bit == 7'(ADDR_START)) begin
                        state_d = ADDR;
                    end else if (next_bit == 7'(ADDR_END)) begin
`ifdef SPI_FLASH_FAST_READ_EN
                        state_d = DUMMY;
                    end else if (next_bit == 7'(ADDR_END + DUMMY_BITS)) begin
`endif
                        state_d = DATA;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= 8'd0;
            bit_q    <= 7'd0;
            guard_q  <= '0;
            tx_q     <= 32'd0;
            rx_q     <= 32'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            guard_q  <= guard_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            sck_q    <= sck_d;
            cs_n_q   <= cs_n_d;
            mosi_q   <= mosi_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Self-checking bench for spi_flash_read_ctrl: three instances (CLK_DIV 2, 1, 5) each with a flash model.
// Build with SPI_FLASH_FAST_READ_EN defined to check the FAST READ variant.
module tb_spi_flash_read_ctrl;

    localparam int N   = 3;
    localparam int DIVS [N] = '{2, 1, 5};
    localparam int CSH = 4;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         TOTAL = 72;
    localparam logic [7:0] OPC   = 8'h0B;
`else
    localparam int         TOTAL = 64;
    localparam logic [7:0] OPC   = 8'h03;
`endif
    localparam int DATA0 = TOTAL - 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [N];
    logic [23:0] addr   [N];
    logic        busy   [N];
    logic        rvalid [N];
    logic [31:0] rdata  [N];
    logic        cs_n   [N];
    logic        sck    [N];
    logic        mosi   [N];
    logic        miso   [N];
    logic [31:0] fdata  [N];
    logic [71:0] mlog   [N];

    int n_checks = 0;
    int n_fail   = 0;
    int rv_cnt0  = 0;

    always #5 clk = ~clk;

    // Flash byte k of the stream is w[8k+7:8k], sent MSB first.
    function automatic logic miso_bit(input int rc, input logic [31:0] w);
        int b;
        b = rc - DATA0;
        if (b < 0 || b > 31) return 1'b0;
        return w[(b / 8) * 8 + 7 - (b % 8)];
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        int          rise_cnt = 0;
        logic        sck_prev = 1'b0;
        logic [71:0] log_r    = '0;

        spi_flash_read_ctrl #(.CLK_DIV(DIVS[g]), .CS_HIGH_CYCLES(CSH), .DATA_BYTES(4)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_i      (req[g]),
            .addr_i     (addr[g]),
            .busy_o     (busy[g]),
            .rvalid_o   (rvalid[g]),
            .rdata_o    (rdata[g]),
            .spi_cs_n_o (cs_n[g]),
            .spi_sck_o  (sck[g]),
            .spi_mosi_o (mosi[g]),
            .spi_miso_i (miso[g])
        );

        always @(negedge clk) begin
            if (cs_n[g]) begin
                rise_cnt <= 0;
                sck_prev <= 1'b0;
            end else begin
                sck_prev <= sck[g];
                if (sck[g] && !sck_prev) begin
                    rise_cnt <= rise_cnt + 1;
                    log_r    <= {log_r[70:0], mosi[g]};
                end
            end
        end

        assign miso[g] = miso_bit(rise_cnt, fdata[g]);
        assign mlog[g] = log_r;
    end

    always @(negedge clk) if (rvalid[0]) rv_cnt0 <= rv_cnt0 + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Issue one read, return data, latency (accept cycle = 1) and SCK phase widths seen while CS_n low.
    task automatic do_read(input int i, input logic [23:0] a, input logic [31:0] w,
                           output logic [31:0] got, output int lat,
                           output int hi_min, output int hi_max, output int lo_min, output int lo_max);
        int   wait_cnt;
        int   run;
        logic prev;
        wait_cnt = 0;
        while (busy[i] && wait_cnt < 5000) begin
            @(negedge clk);
            wait_cnt++;
        end
        fdata[i] = w;
        addr[i]  = a;
        req[i]   = 1'b1;
        lat = 0; run = 0; prev = 1'b0;
        hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
        while (lat < 5000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req[i]  = 1'b0;
                addr[i] = ~a;
            end
            if (rvalid[i]) break;
            if (!cs_n[i]) begin
                if (run > 0 && sck[i] == prev) begin
                    run++;
                end else begin
                    if (run > 0) begin
                        if (prev) begin hi_min = (run < hi_min) ? run : hi_min; hi_max = (run > hi_max) ? run : hi_max; end
                        else      begin lo_min = (run < lo_min) ? run : lo_min; lo_max = (run > lo_max) ? run : lo_max; end
                    end
                    prev = sck[i];
                    run  = 1;
                end
            end
        end
        if (run > 0) begin
            if (prev) begin hi_min = (run < hi_min) ? run : hi_min; hi_max = (run > hi_max) ? run : hi_max; end
            else      begin lo_min = (run < lo_min) ? run : lo_min; lo_max = (run > lo_max) ? run : lo_max; end
        end
        got = rdata[i];
    endtask

    task automatic wait_rvalid(input int i, output int cyc);
        cyc = 0;
        while (cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (rvalid[i]) break;
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [31:0] flash_bytes;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t        vecs [4];
        logic [31:0] got;
        int          lat, hmin, hmax, lmin, lmax, cnt, cs_hi, rv0;

        vecs[0] = '{24'h001001, 32'h44332211, 32'h44332211};
        vecs[1] = '{24'hFFFFFC, 32'hEFBEADDE, 32'hEFBEADDE};
        vecs[2] = '{24'h000000, 32'h0180FF00, 32'h0180FF00};
        vecs[3] = '{24'h800001, 32'h3CC35AA5, 32'h3CC35AA5};

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0; addr[i] = '0; fdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset cs_n",   64'(cs_n[0]),   64'd1);
        check("reset sck",    64'(sck[0]),    64'd0);
        check("reset mosi",   64'(mosi[0]),   64'd0);
        check("reset busy",   64'(busy[0]),   64'd0);
        check("reset rvalid", 64'(rvalid[0]), 64'd0);
        check("reset rdata",  64'(rdata[0]),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            do_read(0, vecs[v].addr, vecs[v].flash_bytes, got, lat, hmin, hmax, lmin, lmax);
            check($sformatf("vec%0d rdata", v), 64'(got), 64'(vecs[v].exp_rdata));
            check($sformatf("vec%0d latency", v), 64'(lat), 64'(1 + 2 * 2 * TOTAL));
            check($sformatf("vec%0d opcode+addr", v), 64'(mlog[0][TOTAL-1 -: 32]), 64'({OPC, vecs[v].addr}));
            check($sformatf("vec%0d data-phase mosi", v), 64'(mlog[0][31:0]), 64'd0);
`ifdef SPI_FLASH_FAST_READ_EN
            check($sformatf("vec%0d dummy bits", v), 64'(mlog[0][39:32]), 64'd0);
`endif
            @(negedge clk);
            check($sformatf("vec%0d rvalid one cycle", v), 64'(rvalid[0]), 64'd0);
            check($sformatf("vec%0d rdata held", v), 64'(rdata[0]), 64'(vecs[v].exp_rdata));
        end

        // Divider sweep over all three instances.
        for (int i = 0; i < N; i++) begin
            do_read(i, 24'h5A5A5A, 32'h87654321, got, lat, hmin, hmax, lmin, lmax);
            check($sformatf("div%0d rdata", DIVS[i]), 64'(got), 64'h87654321);
            check($sformatf("div%0d latency", DIVS[i]), 64'(lat), 64'(1 + 2 * DIVS[i] * TOTAL));
            check($sformatf("div%0d sck high min", DIVS[i]), 64'(hmin), 64'(DIVS[i]));
            check($sformatf("div%0d sck high max", DIVS[i]), 64'(hmax), 64'(DIVS[i]));
            check($sformatf("div%0d sck low min", DIVS[i]), 64'(lmin), 64'(DIVS[i]));
            check($sformatf("div%0d sck low max", DIVS[i]), 64'(lmax), 64'(DIVS[i]));
        end

        // Back-to-back with req held high.
        repeat (10) @(negedge clk);
        fdata[0] = 32'hA1B2C3D4;
        addr[0]  = 24'h000100;
        req[0]   = 1'b1;
        wait_rvalid(0, cnt);
        check("b2b first rdata", 64'(rdata[0]), 64'hA1B2C3D4);
        cnt = 0;
        cs_hi = cs_n[0] ? 1 : 0;
        while (cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cs_n[0]) cs_hi++;
            if (!busy[0]) break;
        end
        check("b2b accept after rvalid", 64'(cnt), 64'(CSH));
        fdata[0] = 32'h0F1E2D3C;
        @(negedge clk);
        req[0] = 1'b0;
        check("b2b second started", 64'({busy[0], cs_n[0]}), 64'b10);
        check("b2b cs_n high >= 4", 64'(cs_hi >= CSH), 64'd1);
        wait_rvalid(0, lat);
        check("b2b second latency", 64'(lat + 1), 64'(1 + 2 * 2 * TOTAL));
        check("b2b second rdata", 64'(rdata[0]), 64'h0F1E2D3C);

        // Request while busy is ignored.
        repeat (10) @(negedge clk);
        rv0 = rv_cnt0;
        fdata[0] = 32'h55AA00FF;
        addr[0]  = 24'h000010;
        req[0]   = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (60) @(negedge clk);
        addr[0] = 24'hABCDEF;
        req[0]  = 1'b1;
        @(negedge clk);
        req[0]  = 1'b0;
        addr[0] = 24'h000000;
        wait_rvalid(0, cnt);
        check("busy-ignore addr", 64'(mlog[0][TOTAL-9 -: 24]), 64'h000010);
        check("busy-ignore rdata", 64'(rdata[0]), 64'h55AA00FF);
        repeat (40) @(negedge clk);
        check("busy-ignore rvalid count", 64'(rv_cnt0 - rv0), 64'd1);
        check("busy-ignore idle after", 64'({busy[0], cs_n[0]}), 64'b01);

        // Reset during the address phase.
        fdata[0] = 32'h11111111;
        addr[0]  = 24'h123456;
        req[0]   = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        repeat (60) @(negedge clk);
        check("pre-reset in transfer", 64'({busy[0], cs_n[0]}), 64'b10);
        rv0 = rv_cnt0;
        rst = 1'b1;
        #1;
        check("mid-reset cs_n",   64'(cs_n[0]),   64'd1);
        check("mid-reset sck",    64'(sck[0]),    64'd0);
        check("mid-reset busy",   64'(busy[0]),   64'd0);
        check("mid-reset rvalid", 64'(rvalid[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("mid-reset no rvalid", 64'(rv_cnt0 - rv0), 64'd0);
        do_read(0, 24'hFFFFFC, 32'hEFBEADDE, got, lat, hmin, hmax, lmin, lmax);
        check("post-reset rdata", 64'(got), 64'hEFBEADDE);
        check("post-reset latency", 64'(lat), 64'(1 + 2 * 2 * TOTAL));
        check("post-reset opcode+addr", 64'(mlog[0][TOTAL-1 -: 32]), 64'({OPC, 24'hFFFFFC}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
